// File: rtl/cr_osf_debug_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cr_osfPKG
//  Description : Shared types and constants for the OSF output-FIFO debug path.
//  Revision    : 1.0 - initial release
// ============================================================================
package cr_osfPKG;

  // Debug mode applied to the output FIFO
  typedef enum logic [1:0] {
    OSF_DBG_NORMAL   = 2'd0,
    OSF_DBG_BLK_RDWR = 2'd1,
    OSF_DBG_BLK_RD   = 2'd2,
    OSF_DBG_SS       = 2'd3
  } osf_debug_mode_e;

  // Debug sequencer states
  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_SWITCH = 2'd1,
    SEQ_STEP   = 2'd2,
    SEQ_GAP    = 2'd3
  } osf_debug_seq_state_e;

  // Default number of cycles to wait for a read-free cycle before forcing a switch
  localparam int OSF_SWITCH_TMO_DEFAULT = 64;

endpackage : cr_osfPKG
`default_nettype wire

// File: rtl/cr_osf_debug_seq.sv
`default_nettype none
// ============================================================================
//  Module      : cr_osf_debug_seq
//  Description : Debug sequencer for the OSF output FIFO. Applies requested
//                debug modes at a read-safe boundary and runs N-step
//                single-step bursts with exactly one FIFO read per step.
//  Revision    : 1.0 - initial release
// ============================================================================
module cr_osf_debug_seq
  import cr_osfPKG::*;
#(
  parameter int SWITCH_TMO = OSF_SWITCH_TMO_DEFAULT,
  parameter int TOTAL_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         cfg_debug_mode,
  input  logic               cfg_step_go,
  input  logic [7:0]         cfg_step_num,
  input  logic               cfg_err_clr,
  input  logic               ob_rd_ok,
  input  logic               fifo_empty,
  output logic [1:0]         fifo_debug_mode,
  output logic               single_step_rd,
  output logic               step_busy,
  output logic [7:0]         step_remaining,
  output logic [TOTAL_W-1:0] step_rd_total,
  output logic               mode_switch_done,
  output logic               step_err
);

  // Timer only needs to reach SWITCH_TMO-1, where the switch is forced
  localparam int TMR_W = (SWITCH_TMO > 2) ? $clog2(SWITCH_TMO) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SWITCH_TMO - 1);

  osf_debug_seq_state_e state_q, state_d;
  osf_debug_mode_e      mode_q, mode_d;
  logic [7:0]           rem_q, rem_d;
  logic [TOTAL_W-1:0]   total_q, total_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  osf_debug_mode_e      mode_req;
  logic                 mode_mismatch;
  logic                 step_read;
  logic                 err_set;

  assign mode_req      = osf_debug_mode_e'(cfg_debug_mode);
  assign mode_mismatch = (mode_req != mode_q);

  // Read enable depends only on the state register and the raw empty flag
  assign single_step_rd = (state_q == SEQ_STEP) && !fifo_empty;
  assign step_read      = single_step_rd && ob_rd_ok;

  assign fifo_debug_mode  = mode_q;
  assign step_busy        = (state_q == SEQ_STEP) || (state_q == SEQ_GAP);
  assign step_remaining   = rem_q;
  assign step_rd_total    = total_q;
  assign mode_switch_done = done_q;
  assign step_err         = err_q;

  // Next-state logic: mode switching, step bursts, counters and error flag
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    total_d = total_q;
    timer_d = timer_q;
    done_d  = 1'b0;
    err_set = 1'b0;

    // A step read is counted even when the burst is aborted in the same cycle
    if (step_read && (total_q != {TOTAL_W{1'b1}})) begin
      total_d = total_q + 1'b1;
    end

    case (state_q)
      SEQ_IDLE: begin
        if (mode_mismatch) begin
          // Pending mode change wins; a concurrent step request is rejected
          state_d = SEQ_SWITCH;
          timer_d = '0;
          err_set = cfg_step_go;
        end else if (cfg_step_go) begin
          if (mode_q != OSF_DBG_SS) begin
            err_set = 1'b1;
          end else if (cfg_step_num != 8'd0) begin
            rem_d   = cfg_step_num;
            state_d = SEQ_STEP;
          end
        end
      end

      SEQ_SWITCH: begin
        err_set = cfg_step_go;
        timer_d = timer_q + 1'b1;
        if (!mode_mismatch) begin
          // Request withdrawn before it was applied
          state_d = SEQ_IDLE;
        end else if (!ob_rd_ok || (timer_q == TMR_LAST)) begin
          mode_d  = mode_req;
          done_d  = 1'b1;
          state_d = SEQ_IDLE;
        end
      end

      SEQ_STEP: begin
        err_set = cfg_step_go;
        if (mode_mismatch) begin
          rem_d   = 8'd0;
          timer_d = '0;
          state_d = SEQ_SWITCH;
        end else if (step_read) begin
          rem_d   = rem_q - 8'd1;
          state_d = (rem_q == 8'd1) ? SEQ_IDLE : SEQ_GAP;
        end
      end

      SEQ_GAP: begin
        err_set = cfg_step_go;
        if (mode_mismatch) begin
          rem_d   = 8'd0;
          timer_d = '0;
          state_d = SEQ_SWITCH;
        end else begin
          state_d = SEQ_STEP;
        end
      end

      default: state_d = SEQ_IDLE;
    endcase

    // A new error takes precedence over a clear in the same cycle
    if (err_set) begin
      err_d = 1'b1;
    end else if (cfg_err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ_IDLE;
      mode_q  <= OSF_DBG_NORMAL;
      rem_q   <= 8'd0;
      total_q <= '0;
      timer_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      total_q <= total_d;
      timer_q <= timer_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule : cr_osf_debug_seq
`default_nettype wire

// File: tb/tb_cr_osf_debug_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cr_osf_debug_seq
//  Description : Directed self-checking bench for cr_osf_debug_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cr_osf_debug_seq;

  localparam int SWITCH_TMO = 64;
  localparam int TOTAL_W    = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         cfg_debug_mode;
  logic               cfg_step_go;
  logic [7:0]         cfg_step_num;
  logic               cfg_err_clr;
  logic               ob_rd_ok;
  logic               fifo_empty;
  logic [1:0]         fifo_debug_mode;
  logic               single_step_rd;
  logic               step_busy;
  logic [7:0]         step_remaining;
  logic [TOTAL_W-1:0] step_rd_total;
  logic               mode_switch_done;
  logic               step_err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cr_osf_debug_seq #(
    .SWITCH_TMO(SWITCH_TMO),
    .TOTAL_W   (TOTAL_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_debug_mode  (cfg_debug_mode),
    .cfg_step_go     (cfg_step_go),
    .cfg_step_num    (cfg_step_num),
    .cfg_err_clr     (cfg_err_clr),
    .ob_rd_ok        (ob_rd_ok),
    .fifo_empty      (fifo_empty),
    .fifo_debug_mode (fifo_debug_mode),
    .single_step_rd  (single_step_rd),
    .step_busy       (step_busy),
    .step_remaining  (step_remaining),
    .step_rd_total   (step_rd_total),
    .mode_switch_done(mode_switch_done),
    .step_err        (step_err)
  );

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consumer that takes every enabled read; returns the number of reads taken
  task automatic consume(input int cycles, output int reads);
    reads = 0;
    for (int i = 0; i < cycles; i++) begin
      ob_rd_ok = single_step_rd;
      if (single_step_rd) reads++;
      tick();
    end
    ob_rd_ok = 1'b0;
  endtask

  // Apply a mode with no reads pending: SWITCH entry, apply, settle
  task automatic set_mode(input logic [1:0] m);
    cfg_debug_mode = m;
    ob_rd_ok = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    vectors++;
    if ({fifo_debug_mode, step_remaining, step_rd_total, mode_switch_done, step_err,
         step_busy, single_step_rd} !== {2'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: mode=%0d rem=%0d total=%0d done=%b err=%b busy=%b rd=%b, required all 0",
               fifo_debug_mode, step_remaining, step_rd_total, mode_switch_done, step_err,
               step_busy, single_step_rd);
    end
  endtask

  task automatic test_mode_switch();
    cfg_debug_mode = 2'd3;
    ob_rd_ok = 1'b0;
    tick();
    vectors++;
    if (fifo_debug_mode !== 2'd0 || mode_switch_done !== 1'b0) begin
      miscompares++;
      $display("FAIL switch_edge1: mode=%0d done=%b, required mode=0 done=0",
               fifo_debug_mode, mode_switch_done);
    end
    tick();
    vectors++;
    if (fifo_debug_mode !== 2'd3 || mode_switch_done !== 1'b1) begin
      miscompares++;
      $display("FAIL switch_edge2: mode=%0d done=%b, required mode=3 done=1",
               fifo_debug_mode, mode_switch_done);
    end
    tick();
    vectors++;
    if (fifo_debug_mode !== 2'd3 || mode_switch_done !== 1'b0) begin
      miscompares++;
      $display("FAIL switch_pulse_end: mode=%0d done=%b, required mode=3 done=0",
               fifo_debug_mode, mode_switch_done);
    end
  endtask

  task automatic test_step_burst();
    int reads;
    logic exp_rd;
    fifo_empty   = 1'b0;
    cfg_step_num = 8'd3;
    cfg_step_go  = 1'b1;
    tick();
    cfg_step_go  = 1'b0;
    reads = 0;
    for (int i = 0; i < 6; i++) begin
      exp_rd = ((i % 2) == 0) ? 1'b1 : 1'b0;
      vectors++;
      if (single_step_rd !== exp_rd) begin
        miscompares++;
        $display("FAIL burst_rd_pattern[%0d]: rd=%b, required %b", i, single_step_rd, exp_rd);
      end
      ob_rd_ok = single_step_rd;
      if (single_step_rd) reads++;
      tick();
    end
    ob_rd_ok = 1'b0;
    vectors++;
    if (reads != 3 || step_rd_total !== 4'd3 || step_busy !== 1'b0 || step_remaining !== 8'd0) begin
      miscompares++;
      $display("FAIL burst_end: reads=%0d total=%0d busy=%b rem=%0d, required reads=3 total=3 busy=0 rem=0",
               reads, step_rd_total, step_busy, step_remaining);
    end
  endtask

  task automatic test_forced_switch();
    int first_n;
    int pulses;
    set_mode(2'd0);
    ob_rd_ok       = 1'b1;
    cfg_debug_mode = 2'd2;
    first_n = -1;
    pulses  = 0;
    // Edge 1 enters SWITCH; SWITCH_TMO more edges force the switch
    for (int n = 1; n <= 80; n++) begin
      tick();
      if (mode_switch_done === 1'b1) begin
        pulses++;
        if (first_n < 0) first_n = n;
      end
    end
    ob_rd_ok = 1'b0;
    vectors++;
    if (first_n != SWITCH_TMO + 1 || pulses != 1 || fifo_debug_mode !== 2'd2) begin
      miscompares++;
      $display("FAIL forced_switch: done_at=%0d pulses=%0d mode=%0d, required done_at=%0d pulses=1 mode=2",
               first_n, pulses, fifo_debug_mode, SWITCH_TMO + 1);
    end
  endtask

  task automatic test_abort();
    set_mode(2'd3);
    cfg_step_num = 8'd6;
    cfg_step_go  = 1'b1;
    tick();
    cfg_step_go  = 1'b0;
    ob_rd_ok = 1'b1;
    tick();
    ob_rd_ok = 1'b0;
    tick();
    vectors++;
    if (step_remaining !== 8'd5 || step_rd_total !== 4'd4 || single_step_rd !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_setup: rem=%0d total=%0d rd=%b, required rem=5 total=4 rd=1",
               step_remaining, step_rd_total, single_step_rd);
    end
    ob_rd_ok       = 1'b1;
    cfg_debug_mode = 2'd0;
    tick();
    ob_rd_ok = 1'b0;
    vectors++;
    if (step_rd_total !== 4'd5 || step_remaining !== 8'd0 || step_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_cycle: total=%0d rem=%0d busy=%b, required total=5 rem=0 busy=0",
               step_rd_total, step_remaining, step_busy);
    end
    tick();
    vectors++;
    if (fifo_debug_mode !== 2'd0 || mode_switch_done !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_apply: mode=%0d done=%b, required mode=0 done=1",
               fifo_debug_mode, mode_switch_done);
    end
  endtask

  task automatic test_step_err();
    int reads;
    tick();
    cfg_step_num = 8'd2;
    cfg_step_go  = 1'b1;
    tick();
    cfg_step_go  = 1'b0;
    vectors++;
    if (step_err !== 1'b1 || step_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL err_normal_go: err=%b busy=%b, required err=1 busy=0", step_err, step_busy);
    end
    cfg_err_clr = 1'b1;
    tick();
    cfg_err_clr = 1'b0;
    vectors++;
    if (step_err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear: err=%b, required 0", step_err);
    end
    set_mode(2'd3);
    cfg_step_num = 8'd3;
    cfg_step_go  = 1'b1;
    tick();
    cfg_step_go  = 1'b0;
    ob_rd_ok = 1'b1;
    tick();
    ob_rd_ok = 1'b0;
    // Now in GAP: a second go must be rejected without touching the burst
    cfg_step_num = 8'd9;
    cfg_step_go  = 1'b1;
    tick();
    cfg_step_go  = 1'b0;
    vectors++;
    if (step_err !== 1'b1 || step_remaining !== 8'd2 || step_busy !== 1'b1 || single_step_rd !== 1'b1) begin
      miscompares++;
      $display("FAIL err_busy_go: err=%b rem=%0d busy=%b rd=%b, required err=1 rem=2 busy=1 rd=1",
               step_err, step_remaining, step_busy, single_step_rd);
    end
    cfg_err_clr = 1'b1;
    cfg_step_go = 1'b1;
    tick();
    cfg_err_clr = 1'b0;
    cfg_step_go = 1'b0;
    vectors++;
    if (step_err !== 1'b1 || step_remaining !== 8'd2) begin
      miscompares++;
      $display("FAIL err_vs_clr: err=%b rem=%0d, required err=1 rem=2", step_err, step_remaining);
    end
    consume(8, reads);
    vectors++;
    if (reads != 2 || step_rd_total !== 4'd8 || step_busy !== 1'b0 || step_remaining !== 8'd0) begin
      miscompares++;
      $display("FAIL err_burst_done: reads=%0d total=%0d busy=%b rem=%0d, required reads=2 total=8 busy=0 rem=0",
               reads, step_rd_total, step_busy, step_remaining);
    end
  endtask

  task automatic test_zero_and_saturation();
    int reads;
    cfg_err_clr = 1'b1;
    tick();
    cfg_err_clr  = 1'b0;
    cfg_step_num = 8'd0;
    cfg_step_go  = 1'b1;
    tick();
    cfg_step_go  = 1'b0;
    vectors++;
    if (step_err !== 1'b0 || step_busy !== 1'b0 || single_step_rd !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_steps: err=%b busy=%b rd=%b, required all 0", step_err, step_busy, single_step_rd);
    end
    cfg_step_num = 8'd10;
    cfg_step_go  = 1'b1;
    tick();
    cfg_step_go  = 1'b0;
    consume(24, reads);
    vectors++;
    if (reads != 10 || step_rd_total !== 4'hF || step_remaining !== 8'd0 || step_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL saturation: reads=%0d total=%0d rem=%0d busy=%b, required reads=10 total=15 rem=0 busy=0",
               reads, step_rd_total, step_remaining, step_busy);
    end
  endtask

  task automatic test_empty_stall();
    cfg_step_num = 8'd2;
    cfg_step_go  = 1'b1;
    fifo_empty   = 1'b1;
    tick();
    cfg_step_go  = 1'b0;
    tick(); tick(); tick();
    vectors++;
    if (single_step_rd !== 1'b0 || step_busy !== 1'b1 || step_remaining !== 8'd2) begin
      miscompares++;
      $display("FAIL empty_stall: rd=%b busy=%b rem=%0d, required rd=0 busy=1 rem=2",
               single_step_rd, step_busy, step_remaining);
    end
    fifo_empty = 1'b0;
    #1;
    vectors++;
    if (single_step_rd !== 1'b1) begin
      miscompares++;
      $display("FAIL empty_release: rd=%b, required 1", single_step_rd);
    end
  endtask

  task automatic test_reset_mid_burst();
    ob_rd_ok = 1'b1;
    tick();
    ob_rd_ok = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cfg_debug_mode = 2'd0;
    vectors++;
    if ({fifo_debug_mode, step_remaining, step_rd_total, mode_switch_done, step_err,
         step_busy, single_step_rd} !== {2'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid_burst: mode=%0d rem=%0d total=%0d done=%b err=%b busy=%b rd=%b, required all 0",
               fifo_debug_mode, step_remaining, step_rd_total, mode_switch_done, step_err,
               step_busy, single_step_rd);
    end
  endtask

  initial begin
    rst            = 1'b1;
    cfg_debug_mode = 2'd0;
    cfg_step_go    = 1'b0;
    cfg_step_num   = 8'd0;
    cfg_err_clr    = 1'b0;
    ob_rd_ok       = 1'b0;
    fifo_empty     = 1'b1;
    #2;
    test_reset();
    test_mode_switch();
    test_step_burst();
    test_forced_switch();
    test_abort();
    test_step_err();
    test_zero_and_saturation();
    test_empty_stall();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_cr_osf_debug_seq
`default_nettype wire
